pwm_multi_axil: RTL
===================

// Module: pwm_multi_axil
// PURPOSE
//  Parametrised successor to the single-channel AXI4-Lite PWM core: N_CH independent PWM
//  channels behind one AXI4-Lite slave port, with per-channel period, duty and polarity.
//  Shadow registers give glitch-free, period-aligned updates.
//  A maskable wrap interrupt is provided. Sits in the PL as a memory-mapped peripheral
//  driven by the PS/master VIP; pwm_out drives pins or downstream logic.
// PARAMETERS
//  N_CH    4   number of PWM channels, 1..8
//  CNT_W   16  period/duty counter width, 2..32
//  ADDR_W  8   AXI address width; must cover 0x10+0x10*N_CH
// PORTS
//  ACLK                      in   1       clock; all logic rising-edge
//  ARESET                    in   1       reset, synchronous, active-high
//  S_AXI_AW{ADDR,PROT,VALID} in   ADDR_W/3/1  write address channel
//  S_AXI_AWREADY             out  1       write address ready
//  S_AXI_W{DATA,STRB,VALID}  in   32/4/1  write data channel
//  S_AXI_WREADY              out  1       write data ready
//  S_AXI_BRESP/BVALID        out  2/1     write response
//  S_AXI_BREADY              in   1       write response ready
//  S_AXI_AR{ADDR,PROT,VALID} in   ADDR_W/3/1  read address channel
//  S_AXI_ARREADY             out  1       read address ready
//  S_AXI_RDATA/RRESP/RVALID  out  32/2/1  read data channel
//  S_AXI_RREADY              in   1       read data ready
//  pwm_out                   out  N_CH    PWM outputs, registered
//  irq                       out  1       level interrupt, registered
// BEHAVIOUR
//  Register map (word offsets; bits above CNT_W/N_CH read 0):
//   0x00 CTRL enable[N_CH-1:0]; 0x04 IRQ_STAT (W1C); 0x08 IRQ_MASK
//   0x0C ID (RO) = {8'h02, N_CH[7:0], CNT_W[7:0], 8'h00}
//   0x10+0x10*k: +0 PERIOD_k, +4 DUTY_k, +8 CFG_k[0] = invert
//  Reset: all registers 0; pwm_out=0; irq=0; all *READY/*VALID=0; BRESP=RRESP=0.
//  Write handshake:
//   - AWREADY and WREADY pulse together for 1 cycle once AWVALID && WVALID && !BVALID.
//   - Register updated on that edge; WSTRB byte lanes honoured.
//   - BVALID asserts the next cycle and holds until BREADY.
//   - Max one write outstanding.
//  Read handshake:
//   - ARREADY pulses 1 cycle when ARVALID && !RVALID.
//   - RDATA/RVALID next cycle, held stable until RREADY.
//  Unmapped or channel-index>=N_CH address: write dropped, BRESP=2'b10;
//   read returns 0, RRESP=2'b10. Writes to ID ignored, BRESP=OKAY.
//  Channel k counter cnt (CNT_W bits):
//   - Counts 0..per_sh-1, then wraps to 0.
//   - Shadows per_sh/duty_sh/inv_sh load from PERIOD/DUTY/CFG on wrap or while disabled.
//   - Raw = (cnt < duty_sh); duty_sh>=per_sh gives constant 1; per_sh=0 gives raw 0,
//     cnt held 0.
//   - pwm_out[k] = raw ^ inv_sh, registered (1-cycle latency from cnt).
//   - Disabled: cnt=0, pwm_out[k]=CFG.invert (idle level).
//   - Enable 0->1: first compare cycle uses cnt=0 with freshly loaded shadows.
//     Channels enabled by the same CTRL write start phase-aligned.
//  IRQ_STAT[k] sets on the cycle cnt wraps per_sh-1 -> 0 (per_sh>=1).
//   - W1C clears; a set coinciding with a clear leaves the bit set.
//   - irq = |(IRQ_STAT & IRQ_MASK), registered.
//  Mid-period PERIOD/DUTY writes never alter the current period's waveform.
//  ARESET mid-transaction: any pending B/R response is abandoned, all state returns to reset.
// STRUCTURE
//  pwm_multi_pkg:
//   - Register offsets (REG_CTRL, REG_IRQ_STAT, REG_IRQ_MASK, REG_ID, CH_BASE, CH_STRIDE).
//   - RESP_OKAY/RESP_SLVERR constants.
//   - ch_cfg_t struct {period, duty, invert}.
//  Sub-module pwm_channel (one per channel, generate loop):
//   - Inputs: enable, ch_cfg_t.
//   - Outputs: pwm, wrap_pulse.
//  Top holds the AXI FSMs, register file and IRQ logic.
// TESTING
//  1) Reset, read 0x0C -> 0x0204_1000; read 0x00..0x08 -> 0; pwm_out=0.
//  2) CH0 PERIOD=10, DUTY=3, CTRL=1 -> pwm_out[0] high 3 cycles, low 7 cycles, repeating.
//  3) Mid-period DUTY0=7 -> current period unchanged; next period high 7 cycles.
//  4) CFG1=1, PERIOD1=4, DUTY1=4 -> before enable pwm_out[1]=1; after enable it stays 0.
//     Set DUTY1=0 -> stays 1.
//  5) IRQ_MASK=1, CH0 running -> irq rises 1 cycle after wrap.
//     Write IRQ_STAT=1 -> irq drops; it re-fires on the next wrap.
//  6) Write 0x50 (ch4, N_CH=4) -> BRESP=2'b10, no state change. Read 0x50 -> 0, RRESP=2'b10.
//     Hold BREADY low 5 cycles -> BVALID held, no second AWREADY.

Source files
------------

// File: rtl/pwm_multi_pkg.sv
// Shared definitions for the multi-channel AXI4-Lite PWM peripheral.
//   - register byte offsets (global block and per-channel block)
//   - AXI response codes
//   - AXI write/read FSM state types
//   - ch_cfg_t: per-channel configuration handed from the register file
//     to each pwm_channel (fields at full 32-bit width; channels use the low
//     CNT_W bits)
//   - byte-strobe helpers for register writes
package pwm_multi_pkg;

  localparam int REG_CTRL     = 'h00;
  localparam int REG_IRQ_STAT = 'h04;
  localparam int REG_IRQ_MASK = 'h08;
  localparam int REG_ID       = 'h0C;
  // Channel k occupies CH_BASE + CH_STRIDE*k. The stride is 16 bytes, so the
  // address bits above [3:0] form the block index (0 = global, k+1 = channel k).
  localparam int CH_BASE      = 'h10;
  localparam int CH_STRIDE    = 'h10;
  localparam int CH_PERIOD    = 'h0;
  localparam int CH_DUTY      = 'h4;
  localparam int CH_CFG       = 'h8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_DATA} rd_state_t;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] duty;
    logic        invert;
  } ch_cfg_t;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{strb[i]}};
    return m;
  endfunction

  // Merge write data into an existing value, byte lanes selected by strb.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] m;
    m = strb_mask(strb);
    return (old_val & ~m) | (wdata & m);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel with period-aligned shadow registers.
//   clk, rst    : clock, synchronous active-high reset
//   enable      : channel run enable (from CTRL)
//   cfg         : live PERIOD/DUTY/CFG register values
//   pwm         : registered PWM output (idle level = cfg.invert when disabled)
//   wrap_pulse  : high during the cycle whose edge wraps cnt per_sh-1 -> 0
module pwm_channel
  import pwm_multi_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    enable,
  input  ch_cfg_t cfg,
  output logic    pwm,
  output logic    wrap_pulse
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] per_sh;
  logic [CNT_W-1:0] duty_sh;
  logic             inv_sh;
  logic             at_end;
  logic             unused_cfg;

  assign unused_cfg = ^{cfg.period, cfg.duty};

  assign at_end     = (per_sh != '0) && (cnt == per_sh - CNT_W'(1));
  assign wrap_pulse = enable && at_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      per_sh  <= '0;
      duty_sh <= '0;
      inv_sh  <= 1'b0;
      pwm     <= 1'b0;
    end else if (!enable) begin
      // Shadows track the registers so the first enabled cycle compares
      // cnt=0 against fresh values; output sits at the idle level.
      cnt     <= '0;
      per_sh  <= cfg.period[CNT_W-1:0];
      duty_sh <= cfg.duty[CNT_W-1:0];
      inv_sh  <= cfg.invert;
      pwm     <= cfg.invert;
    end else begin
      pwm <= ((per_sh != '0) && (cnt < duty_sh)) ^ inv_sh;
      // A zero period has no wrap, so shadows keep reloading; otherwise a
      // running channel with period 0 could never pick up a new period.
      if (at_end || per_sh == '0) begin
        cnt     <= '0;
        per_sh  <= cfg.period[CNT_W-1:0];
        duty_sh <= cfg.duty[CNT_W-1:0];
        inv_sh  <= cfg.invert;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_multi_axil.sv
// N_CH-channel PWM peripheral behind an AXI4-Lite slave port.
//   ACLK/ARESET     : clock, synchronous active-high reset
//   S_AXI_*         : AXI4-Lite slave (AW/W/B write, AR/R read)
//   pwm_out[N_CH]   : registered PWM outputs
//   irq             : registered level interrupt = |(IRQ_STAT & IRQ_MASK)
// Handshake: AWREADY/WREADY pulse together for one cycle after AWVALID and
// WVALID are both seen with no response pending; the register updates on that
// edge, BVALID rises next cycle and holds until BREADY. ARREADY pulses one
// cycle after ARVALID; RDATA/RRESP/RVALID follow and hold until RREADY.
module pwm_multi_axil
  import pwm_multi_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic [2:0]        S_AXI_AWPROT,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic [2:0]        S_AXI_ARPROT,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic [N_CH-1:0]   pwm_out,
  output logic              irq
);

  localparam int          IDX_W    = ADDR_W - 4;
  localparam logic [31:0] ID_VALUE = {8'h02, 8'(N_CH), 8'(CNT_W), 8'h00};

  logic [N_CH-1:0]  ctrl_r, stat_r, mask_r, inv_r, wrap, stat_clr;
  logic [CNT_W-1:0] period_r [N_CH];
  logic [CNT_W-1:0] duty_r   [N_CH];

  wr_state_t   w_state, w_next;
  rd_state_t   r_state, r_next;
  logic        wr_fire, rd_fire;
  logic [1:0]  bresp_r, rresp_r;
  logic [31:0] rdata_r;

  logic [IDX_W-1:0] w_idx, r_idx;
  logic             wr_ok, wr_ctrl, wr_stat, wr_mask;
  logic [N_CH-1:0]  wr_per, wr_duty, wr_cfg;
  logic             rd_ok;
  logic [31:0]      rd_data;
  logic             unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign w_idx     = S_AXI_AWADDR[ADDR_W-1:4];
  assign r_idx     = S_AXI_ARADDR[ADDR_W-1:4];

  // ---------------- write path FSM ----------------
  always_comb begin
    w_next        = w_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    wr_fire       = 1'b0;
    case (w_state)
      W_IDLE:   if (S_AXI_AWVALID && S_AXI_WVALID) w_next = W_ACCEPT;
      W_ACCEPT: begin
        S_AXI_AWREADY = 1'b1;
        S_AXI_WREADY  = 1'b1;
        wr_fire       = 1'b1;
        w_next        = W_RESP;
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // ---------------- read path FSM ----------------
  always_comb begin
    r_next        = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    rd_fire       = 1'b0;
    case (r_state)
      R_IDLE:   if (S_AXI_ARVALID) r_next = R_ACCEPT;
      R_ACCEPT: begin
        S_AXI_ARREADY = 1'b1;
        rd_fire       = 1'b1;
        r_next        = R_DATA;
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      bresp_r <= RESP_OKAY;
      rresp_r <= RESP_OKAY;
      rdata_r <= '0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      if (wr_fire) bresp_r <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (rd_fire) begin
        rdata_r <= rd_data;
        rresp_r <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign S_AXI_BRESP = bresp_r;
  assign S_AXI_RRESP = rresp_r;
  assign S_AXI_RDATA = rdata_r;

  // ---------------- address decode ----------------
  always_comb begin
    wr_ok   = 1'b0;
    wr_ctrl = 1'b0;
    wr_stat = 1'b0;
    wr_mask = 1'b0;
    wr_per  = '0;
    wr_duty = '0;
    wr_cfg  = '0;
    if (w_idx == '0) begin
      wr_ok = 1'b1;  // ID is accepted but has no storage
      case ({S_AXI_AWADDR[3:2], 2'b00})
        4'(REG_CTRL):     wr_ctrl = 1'b1;
        4'(REG_IRQ_STAT): wr_stat = 1'b1;
        4'(REG_IRQ_MASK): wr_mask = 1'b1;
        default: ;
      endcase
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (w_idx == IDX_W'(k + 1)) begin
          case ({S_AXI_AWADDR[3:2], 2'b00})
            4'(CH_PERIOD): begin wr_ok = 1'b1; wr_per[k]  = 1'b1; end
            4'(CH_DUTY):   begin wr_ok = 1'b1; wr_duty[k] = 1'b1; end
            4'(CH_CFG):    begin wr_ok = 1'b1; wr_cfg[k]  = 1'b1; end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    rd_ok   = 1'b0;
    rd_data = '0;
    if (r_idx == '0) begin
      rd_ok = 1'b1;
      case ({S_AXI_ARADDR[3:2], 2'b00})
        4'(REG_CTRL):     rd_data = 32'(ctrl_r);
        4'(REG_IRQ_STAT): rd_data = 32'(stat_r);
        4'(REG_IRQ_MASK): rd_data = 32'(mask_r);
        default:          rd_data = ID_VALUE;
      endcase
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (r_idx == IDX_W'(k + 1)) begin
          case ({S_AXI_ARADDR[3:2], 2'b00})
            4'(CH_PERIOD): begin rd_ok = 1'b1; rd_data = 32'(period_r[k]); end
            4'(CH_DUTY):   begin rd_ok = 1'b1; rd_data = 32'(duty_r[k]);   end
            4'(CH_CFG):    begin rd_ok = 1'b1; rd_data = 32'(inv_r[k]);    end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- register file and interrupt ----------------
  assign stat_clr = (wr_fire && wr_stat) ?
                    N_CH'(S_AXI_WDATA & strb_mask(S_AXI_WSTRB)) : '0;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ctrl_r <= '0;
      stat_r <= '0;
      mask_r <= '0;
      inv_r  <= '0;
      irq    <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        period_r[k] <= '0;
        duty_r[k]   <= '0;
      end
    end else begin
      // Set wins over a coincident W1C clear.
      stat_r <= (stat_r & ~stat_clr) | wrap;
      irq    <= |(stat_r & mask_r);
      if (wr_fire && wr_ctrl)
        ctrl_r <= N_CH'(apply_strb(32'(ctrl_r), S_AXI_WDATA, S_AXI_WSTRB));
      if (wr_fire && wr_mask)
        mask_r <= N_CH'(apply_strb(32'(mask_r), S_AXI_WDATA, S_AXI_WSTRB));
      for (int k = 0; k < N_CH; k++) begin
        if (wr_fire && wr_per[k])
          period_r[k] <= CNT_W'(apply_strb(32'(period_r[k]), S_AXI_WDATA, S_AXI_WSTRB));
        if (wr_fire && wr_duty[k])
          duty_r[k] <= CNT_W'(apply_strb(32'(duty_r[k]), S_AXI_WDATA, S_AXI_WSTRB));
        if (wr_fire && wr_cfg[k] && S_AXI_WSTRB[0])
          inv_r[k] <= S_AXI_WDATA[0];
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    ch_cfg_t cfg;
    assign cfg = '{period: 32'(period_r[k]), duty: 32'(duty_r[k]), invert: inv_r[k]};
    pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk        (ACLK),
      .rst        (ARESET),
      .enable     (ctrl_r[k]),
      .cfg        (cfg),
      .pwm        (pwm_out[k]),
      .wrap_pulse (wrap[k])
    );
  end

endmodule
